// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_dp_clr simple-dual-port RAM.
//   ram_state_t   - clear-engine state encoding (idle / sequential clear)
//   ram_clr_log2  - ceil(log2(value)), used to check DEPTH fits in ADDR_W bits
// Optional feature macro used by the top level: RAM_BYPASS_EN.
package ram_pkg;

  typedef enum logic [0:0] {
    RAM_IDLE  = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int ram_clr_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// ram_clr_fsm: clear engine for ram_dp_clr. After Reset releases it walks
// clrAddr from 0 to DEPTH-1, one word per cycle, then drops Busy.
// Ports:
//   Clk, Reset  - clock, synchronous active-high reset
//   clrWe       - write CLR_VAL into word clrAddr this cycle
//   clrAddr     - word currently being cleared
//   Busy        - registered; high from the Reset edge until the clear completes
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              clrWe,
  output logic [ADDR_W-1:0] clrAddr,
  output logic              Busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;

  // Next-state logic for the clear walk.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    case (state_q)
      RAM_CLEAR: begin
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = RAM_IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_ptr_d = clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      RAM_IDLE: begin
        busy_d = 1'b0;
      end
      default: begin
        // Unreachable encoding: recover by re-running a full clear.
        state_d   = RAM_CLEAR;
        clr_ptr_d = {ADDR_W{1'b0}};
        busy_d    = 1'b1;
      end
    endcase
  end

  // State, pointer and Busy registers; Reset restarts the clear at word 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= RAM_CLEAR;
      clr_ptr_q <= {ADDR_W{1'b0}};
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Holding Reset freezes the walk, so no word is cleared while it is high.
  assign clrWe   = (state_q == RAM_CLEAR) && !Reset;
  assign clrAddr = clr_ptr_q;
  assign Busy    = busy_q;

endmodule

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: parametrised simple-dual-port RAM (one write, one read port)
// with a sequential clear engine started by Reset.
// Ports:
//   Clk, Reset                           - clock, synchronous active-high reset
//   writeEn, writeAddress, WriteData     - write port (dropped while Busy or out of range)
//   readEn, readAddress                  - read port (ignored while Busy)
//   ReadData, readValid                  - registered read result, latency 1
//   Busy                                 - clear engine active
// Macro RAM_BYPASS_EN: when defined, a same-cycle read and write to the same
// address returns the new write data; otherwise the old stored word.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 6,
  parameter int                 DEPTH   = 64,
  parameter logic [DATA_W-1:0]  CLR_VAL = {DATA_W{1'b0}}
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] readAddress,
  output logic [DATA_W-1:0] ReadData,
  output logic              readValid,
  output logic              Busy
);

  if ((DEPTH < 1) || (ram_clr_log2(DEPTH) > ADDR_W)) begin : g_bad_depth
    $error("ram_dp_clr: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
  end

`ifdef RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // One extra bit so DEPTH == 2**ADDR_W does not truncate to zero.
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;

  logic              wr_acc, rd_acc, rd_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;

  ram_clr_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_fsm (
    .Clk     (Clk),
    .Reset   (Reset),
    .clrWe   (clr_we),
    .clrAddr (clr_addr),
    .Busy    (busy)
  );

  // Request acceptance and write-port mux; the clear engine owns the port while active.
  always_comb begin
    wr_acc      = writeEn && !busy && !Reset && ({1'b0, writeAddress} < ADDR_LIM);
    rd_acc      = readEn && !busy && !Reset;
    rd_in_range = ({1'b0, readAddress} < ADDR_LIM);
    mem_we      = 1'b0;
    mem_addr    = clr_addr;
    mem_wdata   = CLR_VAL;
    if (clr_we) begin
      mem_we = 1'b1;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
      mem_addr  = writeAddress;
      mem_wdata = WriteData;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Storage array; no reset, contents are defined by the clear engine.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Next read result; ReadData holds when no read is accepted.
  always_comb begin
    read_valid_d = rd_acc;
    read_data_d  = read_data_q;
    if (rd_acc) begin
      if (!rd_in_range) begin
        read_data_d = {DATA_W{1'b0}};
      end else if (BYPASS && wr_acc && (writeAddress == readAddress)) begin
        read_data_d = WriteData;
      end else begin
        // The array updates on the same edge, so this is the old word.
        read_data_d = mem_q[readAddress];
      end
    end else begin
      read_data_d = read_data_q;
    end
  end

  // Read output register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_valid_q <= 1'b0;
      read_data_q  <= {DATA_W{1'b0}};
    end else begin
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
    end
  end

  assign ReadData  = read_data_q;
  assign readValid = read_valid_q;
  assign Busy      = busy;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: a 64-word instance for the main tests
// and a 48-word instance for out-of-range behaviour. Honours RAM_BYPASS_EN.
module tb_ram_dp_clr;

  logic       Clk = 1'b0;
  logic       Reset, writeEn, readEn;
  logic [5:0] writeAddress, readAddress;
  logic [7:0] WriteData, ReadData;
  logic       readValid, Busy;

  logic       Reset48, writeEn48, readEn48;
  logic [5:0] writeAddress48, readAddress48;
  logic [7:0] WriteData48, ReadData48;
  logic       readValid48, Busy48;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  ram_dp_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .CLR_VAL(8'h00)) u_dut (
    .Clk(Clk), .Reset(Reset), .writeEn(writeEn), .writeAddress(writeAddress),
    .WriteData(WriteData), .readEn(readEn), .readAddress(readAddress),
    .ReadData(ReadData), .readValid(readValid), .Busy(Busy)
  );

  ram_dp_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .CLR_VAL(8'h00)) u_dut48 (
    .Clk(Clk), .Reset(Reset48), .writeEn(writeEn48), .writeAddress(writeAddress48),
    .WriteData(WriteData48), .readEn(readEn48), .readAddress(readAddress48),
    .ReadData(ReadData48), .readValid(readValid48), .Busy(Busy48)
  );

`ifdef RAM_BYPASS_EN
  localparam logic [7:0] EXP_SAME = 8'h3C;
`else
  localparam logic [7:0] EXP_SAME = 8'h11;
`endif

  typedef struct {
    logic       we;
    logic [5:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [5:0] ra;
    logic       exp_v;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    writeEn = 1'b0; writeAddress = 6'd0; WriteData = 8'h00;
    readEn  = 1'b0; readAddress  = 6'd0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < 64; a++) begin
      readEn = 1'b1; readAddress = 6'(a);
      step();
      chk({nm, "_valid"}, 32'(readValid), 32'd1);
      chk({nm, "_data"}, 32'(ReadData), 32'h00);
    end
    readEn = 1'b0;
  endtask

  initial begin
    int cnt;
    Reset = 1'b1;
    idle_inputs();
    Reset48 = 1'b0; writeEn48 = 1'b0; writeAddress48 = 6'd0; WriteData48 = 8'h00;
    readEn48 = 1'b0; readAddress48 = 6'd0;

    vecs[0]  = '{1'b1, 6'd5,  8'hA5, 1'b0, 6'd0,  1'b0, 8'h00};
    vecs[1]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd5,  1'b1, 8'hA5};
    vecs[2]  = '{1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 6'd9,  8'h11, 1'b0, 6'd0,  1'b0, 8'hA5};
    vecs[4]  = '{1'b1, 6'd9,  8'h3C, 1'b1, 6'd9,  1'b1, EXP_SAME};
    vecs[5]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd9,  1'b1, 8'h3C};
    vecs[6]  = '{1'b1, 6'd10, 8'hC3, 1'b1, 6'd5,  1'b1, 8'hA5};
    vecs[7]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd10, 1'b1, 8'hC3};
    vecs[8]  = '{1'b1, 6'd63, 8'h7E, 1'b0, 6'd0,  1'b0, 8'hC3};
    vecs[9]  = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd63, 1'b1, 8'h7E};
    vecs[10] = '{1'b1, 6'd0,  8'h81, 1'b1, 6'd63, 1'b1, 8'h7E};
    vecs[11] = '{1'b0, 6'd0,  8'h00, 1'b1, 6'd0,  1'b1, 8'h81};

    // Test 1: reset pulse, clear duration, then every word reads as zero.
    step();
    Reset = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd1);
    chk("rst_valid", 32'(readValid), 32'd0);
    chk("rst_data", 32'(ReadData), 32'h00);
    cnt = 0;
    readEn = 1'b1;
    while (Busy === 1'b1 && cnt < 200) begin
      readAddress = 6'(cnt);
      step();
      cnt++;
      chk("clr_valid", 32'(readValid), 32'd0);
      chk("clr_data", 32'(ReadData), 32'h00);
    end
    readEn = 1'b0;
    chk("clr_busy_cycles", 32'(cnt), 32'd64);
    read_all_zero("t1_read");

    // Tests 2 and 3: directed vector table.
    for (int i = 0; i < 12; i++) begin
      writeEn = vecs[i].we; writeAddress = vecs[i].wa; WriteData = vecs[i].wd;
      readEn  = vecs[i].re; readAddress  = vecs[i].ra;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(readValid), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d_data", i), 32'(ReadData), 32'(vecs[i].exp_d));
    end
    idle_inputs();

    // Fill every word with a nonzero pattern and read it back.
    for (int a = 0; a < 64; a++) begin
      writeEn = 1'b1; writeAddress = 6'(a); WriteData = 8'(a) + 8'h40;
      step();
    end
    writeEn = 1'b0;
    for (int a = 0; a < 64; a += 7) begin
      readEn = 1'b1; readAddress = 6'(a);
      step();
      chk($sformatf("fill_rd%0d", a), 32'(ReadData), 32'(8'(a) + 8'h40));
    end
    idle_inputs();

    // Test 4: reset again, abort 20 cycles in, requests while Busy are ignored.
    pulse_reset();
    for (int k = 0; k < 20; k++) step();
    chk("mid_clear_busy", 32'(Busy), 32'd1);
    pulse_reset();
    cnt = 0;
    while (Busy === 1'b1 && cnt < 200) begin
      readEn = 1'b1; readAddress = 6'd2;
      writeEn = (cnt >= 10); writeAddress = 6'd2; WriteData = 8'h77;
      step();
      cnt++;
      chk("restart_valid", 32'(readValid), 32'd0);
    end
    idle_inputs();
    chk("restart_busy_cycles", 32'(cnt), 32'd64);
    read_all_zero("t4_read");

    // Test 5: 48-word instance, out-of-range write dropped and read as zero.
    Reset48 = 1'b1;
    step();
    Reset48 = 1'b0;
    cnt = 0;
    while (Busy48 === 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    chk("d48_busy_cycles", 32'(cnt), 32'd48);
    writeEn48 = 1'b1; writeAddress48 = 6'd47; WriteData48 = 8'h47;
    step();
    writeAddress48 = 6'd50; WriteData48 = 8'hFF;
    step();
    writeEn48 = 1'b0;
    readEn48 = 1'b1; readAddress48 = 6'd47;
    step();
    chk("d48_rd47_data", 32'(ReadData48), 32'h47);
    readAddress48 = 6'd50;
    step();
    chk("d48_rd50_valid", 32'(readValid48), 32'd1);
    chk("d48_rd50_data", 32'(ReadData48), 32'h00);
    readAddress48 = 6'd47;
    step();
    chk("d48_rd47_intact", 32'(ReadData48), 32'h47);
    readEn48 = 1'b0;
    step();
    chk("d48_idle_valid", 32'(readValid48), 32'd0);
    chk("d48_idle_hold", 32'(ReadData48), 32'h47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
